// File: rtl/line_raster.sv
// line_raster: Bresenham line rasteriser.
// Accepts one clipped segment at a time and streams its pixels, one per
// accepted handshake, from (x0, y0) to (x1, y1) inclusive.
module line_raster #(
  parameter int COORD_W = 16
) (
  input  logic               clkin,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] x0_in,
  input  logic [COORD_W-1:0] y0_in,
  input  logic [COORD_W-1:0] x1_in,
  input  logic [COORD_W-1:0] y1_in,
  input  logic               line_valid,
  output logic               line_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last,
  output logic               line_done,
  output logic               busy
);

  // Error terms carry two extra bits: one for the sign and one so that
  // dx + dy cannot overflow. Doubling the error needs one more bit still.
  localparam int AW = COORD_W + 2;
  localparam int EW = COORD_W + 3;

  localparam logic [COORD_W-1:0] ONE  = {{(COORD_W-1){1'b0}}, 1'b1};
  localparam logic signed [AW-1:0] ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRAW  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Latched segment endpoints.
  logic [COORD_W-1:0] x0;
  logic [COORD_W-1:0] y0;
  logic [COORD_W-1:0] x1;
  logic [COORD_W-1:0] y1;

  // Walker state.
  logic [COORD_W-1:0] cur_x;
  logic [COORD_W-1:0] cur_y;
  logic signed [AW-1:0] dx;
  logic signed [AW-1:0] dy;
  logic signed [AW-1:0] err;
  logic               x_dec;
  logic               y_dec;

  // Registered control outputs.
  logic ready_q;
  logic done_q;

  // Handshake and step decode.
  logic accept_line;
  logic accept_pix;
  logic at_end;
  logic step_x;
  logic step_y;
  logic signed [EW-1:0] e2;
  logic signed [EW-1:0] dx_ext;
  logic signed [EW-1:0] dy_ext;
  logic signed [AW-1:0] err_step;

  // |a - b| as a non-negative signed error-width value.
  function automatic logic signed [AW-1:0] abs_diff(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b
  );
    logic [COORD_W-1:0] mag;
    if (a >= b) begin
      mag = a - b;
    end else begin
      mag = b - a;
    end
    abs_diff = $signed({2'b00, mag});
  endfunction

  // One unit step along an axis, wrapping is impossible for valid segments.
  function automatic logic [COORD_W-1:0] step_coord(
    input logic [COORD_W-1:0] c,
    input logic               dec
  );
    if (dec) begin
      step_coord = c - ONE;
    end else begin
      step_coord = c + ONE;
    end
  endfunction

  // Handshake, end-of-segment and Bresenham decision terms.
  always_comb begin
    accept_line = (state == IDLE) && line_valid && ready_q;
    accept_pix  = (state == DRAW) && pix_ready;
    at_end      = (cur_x == x1) && (cur_y == y1);
    e2          = $signed({err, 1'b0});
    dx_ext      = $signed({dx[AW-1], dx});
    dy_ext      = $signed({dy[AW-1], dy});
    step_x      = (e2 >= dy_ext);
    step_y      = (e2 <= dx_ext);
    err_step    = err + (step_x ? dy : ZERO) + (step_y ? dx : ZERO);
  end

  // State register.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_line) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = DRAW;
      end
      DRAW: begin
        if (accept_pix && at_end) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Endpoint capture on segment acceptance; inputs are ignored otherwise.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      x0 <= '0;
      y0 <= '0;
      x1 <= '0;
      y1 <= '0;
    end else if (accept_line) begin
      x0 <= x0_in;
      y0 <= y0_in;
      x1 <= x1_in;
      y1 <= y1_in;
    end
  end

  // Setup of deltas and directions, then one Bresenham step per accepted pixel.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      cur_x <= '0;
      cur_y <= '0;
      dx    <= '0;
      dy    <= '0;
      err   <= '0;
      x_dec <= 1'b0;
      y_dec <= 1'b0;
    end else if (state == SETUP) begin
      cur_x <= x0;
      cur_y <= y0;
      dx    <= abs_diff(x1, x0);
      dy    <= -abs_diff(y1, y0);
      err   <= abs_diff(x1, x0) - abs_diff(y1, y0);
      x_dec <= !(x0 < x1);
      y_dec <= !(y0 < y1);
    end else if (accept_pix && !at_end) begin
      err <= err_step;
      if (step_x) begin
        cur_x <= step_coord(cur_x, x_dec);
      end
      if (step_y) begin
        cur_y <= step_coord(cur_y, y_dec);
      end
    end
  end

  // line_ready follows the state we are entering; line_done pulses after the last pixel.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_nxt == IDLE);
      done_q  <= accept_pix && at_end;
    end
  end

  // Output mapping.
  always_comb begin
    line_ready = ready_q;
    line_done  = done_q;
    pix_x      = cur_x;
    pix_y      = cur_y;
    pix_valid  = (state == DRAW);
    pix_last   = (state == DRAW) && at_end;
    busy       = (state != IDLE);
  end

endmodule

// File: tb/tb_line_raster.sv
// Directed bench for line_raster with an expected-pixel scoreboard.
module tb_line_raster;

  localparam int W = 16;

  logic         clkin;
  logic         rst_n;
  logic [W-1:0] x0_in;
  logic [W-1:0] y0_in;
  logic [W-1:0] x1_in;
  logic [W-1:0] y1_in;
  logic         line_valid;
  logic         line_ready;
  logic [W-1:0] pix_x;
  logic [W-1:0] pix_y;
  logic         pix_valid;
  logic         pix_ready;
  logic         pix_last;
  logic         line_done;
  logic         busy;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         last;
  } px_t;

  px_t q[$];
  int  checks;
  int  failures;

  line_raster #(.COORD_W(W)) dut (
    .clkin      (clkin),
    .rst_n      (rst_n),
    .x0_in      (x0_in),
    .y0_in      (y0_in),
    .x1_in      (x1_in),
    .y1_in      (y1_in),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .line_done  (line_done),
    .busy       (busy)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int x, input int y, input bit last);
    px_t p;
    p.x = x[W-1:0];
    p.y = y[W-1:0];
    p.last = last;
    q.push_back(p);
  endtask

  // Present a segment once line_ready is seen; returns at the negedge of the SETUP cycle.
  // With keep set, line_valid stays high carrying junk endpoints that must be ignored.
  task automatic send_line(input int ax, input int ay, input int bx, input int by, input bit keep);
    int g;
    g = 0;
    while (!line_ready && g < 20) begin
      @(negedge clkin);
      g++;
    end
    check("ready_before_accept", line_ready, 1);
    x0_in = ax[W-1:0];
    y0_in = ay[W-1:0];
    x1_in = bx[W-1:0];
    y1_in = by[W-1:0];
    line_valid = 1'b1;
    @(negedge clkin);
    check("ready_cleared", line_ready, 0);
    check("busy_setup", busy, 1);
    check("setup_no_pix", pix_valid, 0);
    check("done_one_cycle", line_done, 0);
    if (keep) begin
      x0_in = 16'd9;
      y0_in = 16'd9;
      x1_in = 16'd1;
      y1_in = 16'd2;
    end else begin
      line_valid = 1'b0;
    end
  endtask

  // Compare every shown pixel against the scoreboard head; optionally stall
  // pixel stall_idx for stall_n cycles, or return early while showing abort_idx.
  task automatic run_pixels(input int stall_idx, input int stall_n, input int abort_idx,
                            input int exp_cycles);
    int idx;
    int stalls;
    int cyc;
    bit done;
    px_t e;
    idx = 0;
    stalls = 0;
    cyc = 0;
    done = 0;
    pix_ready = 1'b1;
    @(negedge clkin);
    check("first_valid_latency", pix_valid, 1);
    while (!done && cyc < 64) begin
      if (!pix_valid || q.size() == 0) begin
        check("pix_valid_expected", {pix_valid, 32'(q.size())}, {1'b1, 32'(q.size())});
        break;
      end
      e = q[0];
      check($sformatf("pixel%0d", idx), {pix_x, pix_y, pix_last}, {e.x, e.y, e.last});
      if (idx == abort_idx) return;
      cyc++;
      if (idx == stall_idx && stalls < stall_n) begin
        pix_ready = 1'b0;
        stalls++;
      end else begin
        pix_ready = 1'b1;
        void'(q.pop_front());
        idx++;
        if (e.last) begin
          done = 1;
          line_valid = 1'b0;
        end
      end
      @(negedge clkin);
    end
    check("segment_finished", done, 1);
    check("pixel_cycles", cyc, exp_cycles);
    check("done_pulse", line_done, 1);
    check("valid_cleared", pix_valid, 0);
    check("last_cleared", pix_last, 0);
    check("ready_restored", line_ready, 1);
    check("busy_cleared", busy, 0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    line_valid = 1'b0;
    pix_ready = 1'b1;
    x0_in = '0;
    y0_in = '0;
    x1_in = '0;
    y1_in = '0;

    // Reset state.
    #3;
    check("rst_ready", line_ready, 0);
    check("rst_valid", pix_valid, 0);
    check("rst_last", pix_last, 0);
    check("rst_done", line_done, 0);
    check("rst_busy", busy, 0);
    check("rst_pix", {pix_x, pix_y}, 0);
    @(negedge clkin);
    @(negedge clkin);
    check("rst_hold_ready", line_ready, 0);
    rst_n = 1'b1;
    check("release_ready_low", line_ready, 0);
    @(negedge clkin);
    check("release_ready_high", line_ready, 1);

    // Degenerate point.
    push(5, 5, 1);
    send_line(5, 5, 5, 5, 0);
    run_pixels(-1, 0, -1, 1);

    // Horizontal, back to back with the previous line_done cycle.
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 0); push(3, 0, 1);
    send_line(0, 0, 3, 0, 0);
    run_pixels(-1, 0, -1, 4);

    // Reverse diagonal with line_valid held high carrying junk.
    push(3, 3, 0); push(2, 2, 0); push(1, 1, 0); push(0, 0, 1);
    send_line(3, 3, 0, 0, 1);
    run_pixels(-1, 0, -1, 4);

    // Shallow slope.
    push(0, 0, 0); push(1, 1, 0); push(2, 1, 0); push(3, 2, 0); push(4, 2, 1);
    send_line(0, 0, 4, 2, 0);
    run_pixels(-1, 0, -1, 5);

    // Horizontal with three stall cycles on (1,0).
    push(0, 0, 0); push(1, 0, 0); push(2, 0, 0); push(3, 0, 1);
    send_line(0, 0, 3, 0, 0);
    run_pixels(1, 3, -1, 7);

    // Top-of-range coordinates, decreasing on both axes.
    push(65535, 65535, 0); push(65534, 65534, 0); push(65533, 65534, 1);
    send_line(65535, 65535, 65533, 65534, 0);
    run_pixels(-1, 0, -1, 3);

    // Reset while showing (2,1) of the shallow segment.
    push(0, 0, 0); push(1, 1, 0); push(2, 1, 0); push(3, 2, 0); push(4, 2, 1);
    send_line(0, 0, 4, 2, 0);
    run_pixels(-1, 0, 2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_valid", pix_valid, 0);
    check("abort_last", pix_last, 0);
    check("abort_ready", line_ready, 0);
    check("abort_busy", busy, 0);
    check("abort_done", line_done, 0);
    check("abort_pix", {pix_x, pix_y}, 0);
    @(negedge clkin);
    check("abort_no_done", line_done, 0);
    check("abort_still_idle", {pix_valid, busy}, 0);
    rst_n = 1'b1;
    check("abort_release_ready_low", line_ready, 0);
    @(negedge clkin);
    check("abort_release_ready_high", line_ready, 1);
    check("abort_no_done_after", line_done, 0);
    check("abort_no_pixel", pix_valid, 0);
    q.delete();

    push(7, 7, 1);
    send_line(7, 7, 7, 7, 0);
    run_pixels(-1, 0, -1, 1);
    @(negedge clkin);
    check("final_done_dropped", line_done, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
